// File: rtl/led_cube_pattern_sched.sv
// Round-robin pattern scheduler for the 3x3x3 LED cube, one frame per 1 Hz clock.
// Optional LED_CUBE_HOLD_EN adds a 'hold' input that freezes a running pattern.
module led_cube_pattern_sched #(
  parameter int unsigned REPEATS = 2
) (
  input  logic       clk_1Hz,
  input  logic       reset_n,
  input  logic       req_test,
  input  logic       req_plane,
  input  logic       req_diag,
  input  logic       req_col,
`ifdef LED_CUBE_HOLD_EN
  input  logic       hold,
`endif
  output logic [2:0] vert_pwr_n,
  output logic [2:0] row_bot,
  output logic [2:0] row_mid,
  output logic [2:0] row_top,
  output logic [2:0] grant,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TEST  = 3'd1;
  localparam logic [2:0] PLANE = 3'd2;
  localparam logic [2:0] DIAG  = 3'd3;
  localparam logic [2:0] COL   = 3'd4;

  localparam logic [3:0] LAST_REP = 4'(REPEATS - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [3:0] rep_q, rep_d;
  logic [2:0] pending_q, pending_d;
  logic [1:0] lastGrant_q, lastGrant_d;
  logic [2:0] vert_q, vert_d;
  logic [2:0] bot_q, bot_d;
  logic [2:0] mid_q, mid_d;
  logic [2:0] top_q, top_d;
  logic [2:0] grant_q, grant_d;

  logic       holdActive;
  logic [1:0] stepEff;
  logic [1:0] pickIdx;
  logic       pickValid;
  logic [2:0] clearMask;
  logic [2:0] levelMask;

`ifdef LED_CUBE_HOLD_EN
  assign holdActive = hold;
`else
  assign holdActive = 1'b0;
`endif

  assign stepEff = (step_q == 2'd3) ? 2'd0 : step_q;

  // Round-robin search starts at the pattern after the last one granted.
  always_comb begin
    pickIdx   = 2'd0;
    pickValid = |pending_q;
    case (lastGrant_q)
      2'd0: begin
        if (pending_q[1])      pickIdx = 2'd1;
        else if (pending_q[2]) pickIdx = 2'd2;
        else                   pickIdx = 2'd0;
      end
      2'd1: begin
        if (pending_q[2])      pickIdx = 2'd2;
        else if (pending_q[0]) pickIdx = 2'd0;
        else                   pickIdx = 2'd1;
      end
      default: begin
        if (pending_q[0])      pickIdx = 2'd0;
        else if (pending_q[1]) pickIdx = 2'd1;
        else                   pickIdx = 2'd2;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = stepEff;
    rep_d       = rep_q;
    lastGrant_d = lastGrant_q;
    clearMask   = 3'b000;
    if (req_test) begin
      state_d = TEST;
      step_d  = 2'd0;
      rep_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            lastGrant_d = pickIdx;
            clearMask   = 3'b001 << pickIdx;
            step_d      = 2'd0;
            rep_d       = 4'd0;
            case (pickIdx)
              2'd0:    state_d = PLANE;
              2'd1:    state_d = DIAG;
              default: state_d = COL;
            endcase
          end
        end
        PLANE, DIAG, COL: begin
          if (!holdActive) begin
            if (stepEff == 2'd2) begin
              step_d = 2'd0;
              if (rep_q >= LAST_REP) begin
                state_d = IDLE;
                rep_d   = 4'd0;
              end else begin
                rep_d = rep_q + 4'd1;
              end
            end else begin
              step_d = stepEff + 2'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = 2'd0;
          rep_d   = 4'd0;
        end
      endcase
    end
    // Requests OR in after the grant clear so a re-request is never lost.
    pending_d = (pending_q & ~clearMask) | {req_col, req_diag, req_plane};
  end

  // Frame decode of the next state, so the pins change on the same edge as the FSM.
  always_comb begin
    levelMask = 3'b001 << step_d;
    vert_d    = 3'b000;
    bot_d     = 3'b000;
    mid_d     = 3'b000;
    top_d     = 3'b000;
    grant_d   = 3'b000;
    case (state_d)
      TEST: begin
        bot_d = 3'b111;
        mid_d = 3'b111;
        top_d = 3'b111;
      end
      PLANE: begin
        vert_d  = ~levelMask;
        bot_d   = {3{levelMask[0]}};
        mid_d   = {3{levelMask[1]}};
        top_d   = {3{levelMask[2]}};
        grant_d = 3'b001;
      end
      DIAG: begin
        vert_d  = ~levelMask;
        bot_d   = {3{levelMask[0]}} & levelMask;
        mid_d   = {3{levelMask[1]}} & levelMask;
        top_d   = {3{levelMask[2]}} & levelMask;
        grant_d = 3'b010;
      end
      COL: begin
        bot_d   = levelMask;
        mid_d   = levelMask;
        top_d   = levelMask;
        grant_d = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      rep_q       <= 4'd0;
      pending_q   <= 3'b000;
      lastGrant_q <= 2'd2;
      vert_q      <= 3'b000;
      bot_q       <= 3'b000;
      mid_q       <= 3'b000;
      top_q       <= 3'b000;
      grant_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rep_q       <= rep_d;
      pending_q   <= pending_d;
      lastGrant_q <= lastGrant_d;
      vert_q      <= vert_d;
      bot_q       <= bot_d;
      mid_q       <= mid_d;
      top_q       <= top_d;
      grant_q     <= grant_d;
    end
  end

  assign vert_pwr_n = vert_q;
  assign row_bot    = bot_q;
  assign row_mid    = mid_q;
  assign row_top    = top_q;
  assign grant      = grant_q;
  assign state      = state_q;

endmodule

// File: tb/tb_led_cube_pattern_sched.sv
// Bench for led_cube_pattern_sched: frame-level reference model checked every cycle
// plus literal frame checks; hold scenario only when LED_CUBE_HOLD_EN is defined.
module tb_led_cube_pattern_sched;

  localparam int REP = 2;

  logic       clk_1Hz   = 1'b0;
  logic       reset_n   = 1'b1;
  logic       req_test  = 1'b0;
  logic       req_plane = 1'b0;
  logic       req_diag  = 1'b0;
  logic       req_col   = 1'b0;
  logic       hold      = 1'b0;
  logic [2:0] vert_pwr_n, row_bot, row_mid, row_top, grant, state;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Model: mode 0 idle, 1 test, 2/3/4 plane/diag/col; frame index runs 0..3*REP-1.
  int         mMode, mFrame, mLast;
  logic [2:0] mPend;
  logic       holdNow;

  always #5 clk_1Hz = ~clk_1Hz;

  led_cube_pattern_sched #(.REPEATS(REP)) dut (
    .clk_1Hz   (clk_1Hz),
    .reset_n   (reset_n),
    .req_test  (req_test),
    .req_plane (req_plane),
    .req_diag  (req_diag),
    .req_col   (req_col),
`ifdef LED_CUBE_HOLD_EN
    .hold      (hold),
`endif
    .vert_pwr_n(vert_pwr_n),
    .row_bot   (row_bot),
    .row_mid   (row_mid),
    .row_top   (row_top),
    .grant     (grant),
    .state     (state)
  );

`ifdef LED_CUBE_HOLD_EN
  assign holdNow = hold;
`else
  assign holdNow = 1'b0;
`endif

  always @(posedge clk_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      mMode = 0; mFrame = 0; mLast = 2; mPend = 3'b000;
    end else begin
      if (req_test) begin
        mMode = 1; mFrame = 0;
      end else if (mMode == 1) begin
        mMode = 0;
      end else if (mMode == 0) begin
        bit found;
        found = 1'b0;
        for (int n = 1; n <= 3; n++) begin
          int c;
          c = (mLast + n) % 3;
          if (!found && mPend[c]) begin
            found = 1'b1;
            mPend[c] = 1'b0;
            mLast = c;
            mMode = 2 + c;
            mFrame = 0;
          end
        end
      end else if (!holdNow) begin
        if (mFrame == 3 * REP - 1) mMode = 0;
        else mFrame = mFrame + 1;
      end
      mPend = mPend | {req_col, req_diag, req_plane};
    end
  end

  task automatic computeExp(output logic [2:0] v, output logic [2:0] b, output logic [2:0] m,
                            output logic [2:0] t, output logic [2:0] g, output logic [2:0] s);
    int k;
    int rows[3];
    int vi;
    k = mFrame % 3;
    vi = 0;
    for (int l = 0; l < 3; l++) rows[l] = 0;
    case (mMode)
      1: for (int l = 0; l < 3; l++) rows[l] = 7;
      2: begin vi = 7 - (1 << k); rows[k] = 7; end
      3: begin vi = 7 - (1 << k); rows[k] = 1 << k; end
      4: for (int l = 0; l < 3; l++) rows[l] = 1 << k;
      default: ;
    endcase
    v = 3'(vi);
    b = 3'(rows[0]);
    m = 3'(rows[1]);
    t = 3'(rows[2]);
    g = (mMode >= 2) ? 3'(1 << (mMode - 2)) : 3'b000;
    s = 3'(mMode);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [2:0] v, input logic [2:0] b,
                            input logic [2:0] m, input logic [2:0] t, input logic [2:0] g,
                            input logic [2:0] s);
    checkOutput({tag, ".vert"}, vert_pwr_n, v);
    checkOutput({tag, ".bot"}, row_bot, b);
    checkOutput({tag, ".mid"}, row_mid, m);
    checkOutput({tag, ".top"}, row_top, t);
    checkOutput({tag, ".grant"}, grant, g);
    checkOutput({tag, ".state"}, state, s);
  endtask

  always @(negedge clk_1Hz) begin
    if (checkEn) begin
      logic [2:0] ev, eb, em, et, eg, es;
      computeExp(ev, eb, em, et, eg, es);
      checkFrame("model", ev, eb, em, et, eg, es);
    end
  end

  task automatic applyStimulus(input logic p, input logic d, input logic c, input logic t);
    req_plane = p;
    req_diag  = d;
    req_col   = c;
    req_test  = t;
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    #4;
  endtask

  initial begin
    $display("[TB] start");
    #1 reset_n = 1'b0;
    #1 checkFrame("reset", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    tick(); tick();
    reset_n = 1'b1;
    checkEn = 1'b1;

    // Three simultaneous requests: plane, diag, col in turn with a blank frame between.
    applyStimulus(1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    checkFrame("rr_plane0", 3'b110, 3'b111, 3'b000, 3'b000, 3'b001, 3'd2);
    repeat (5) tick();
    tick();
    checkFrame("rr_gap1", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    tick();
    checkFrame("rr_diag0", 3'b110, 3'b001, 3'b000, 3'b000, 3'b010, 3'd3);
    repeat (5) tick();
    tick();
    checkFrame("rr_gap2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    tick();
    checkFrame("rr_col0", 3'b000, 3'b001, 3'b001, 3'b001, 3'b100, 3'd4);
    tick();
    checkFrame("col_step1", 3'b000, 3'b010, 3'b010, 3'b010, 3'b100, 3'd4);
    repeat (4) tick();
    tick();
    checkFrame("rr_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    repeat (3) tick();
    checkFrame("rr_drained", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

    // Single plane pulse: full six-frame sequence.
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    checkFrame("plane_f0", 3'b110, 3'b111, 3'b000, 3'b000, 3'b001, 3'd2);
    tick();
    checkFrame("plane_f1", 3'b101, 3'b000, 3'b111, 3'b000, 3'b001, 3'd2);
    tick();
    checkFrame("plane_f2", 3'b011, 3'b000, 3'b000, 3'b111, 3'b001, 3'd2);
    tick();
    checkFrame("plane_f3", 3'b110, 3'b111, 3'b000, 3'b000, 3'b001, 3'd2);
    repeat (2) tick();
    tick();
    checkFrame("plane_done", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

    // Test preempts diag on its second frame; diag is dropped.
    applyStimulus(0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick(); tick();
    applyStimulus(0, 0, 0, 1);
    tick();
    checkFrame("test_on", 3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 3'd1);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    checkFrame("test_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    tick();
    checkFrame("diag_dropped", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

    // Re-requested diag survives a test abort and reruns afterwards.
    applyStimulus(0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    checkFrame("diag_rerun", 3'b110, 3'b001, 3'b000, 3'b000, 3'b010, 3'd3);
    repeat (6) tick();

    // Plane re-requested while running reruns after a blank frame.
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick(); tick();
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (12) tick();

    // Asynchronous reset mid-frame also wipes a pending col request.
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 checkFrame("async_rst", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checkFrame("rst_pending_clr", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

`ifdef LED_CUBE_HOLD_EN
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick(); tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkFrame("hold_frz", 3'b101, 3'b000, 3'b111, 3'b000, 3'b001, 3'd2);
    end
    hold = 1'b0;
    tick();
    checkFrame("hold_rel", 3'b011, 3'b000, 3'b000, 3'b111, 3'b001, 3'd2);
    repeat (5) tick();
`endif

    tick();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
